// File: rtl/noc_switch_node.sv
// Two-input, two-output NoC switch node: routes each valid word on one ADD bit,
// with round-robin arbitration per output and registered, stallable output lanes.
module noc_switch_node #(
  parameter int bit_width = 4,
  parameter int log_n_add = 3,
  parameter int ctrl_bit  = 1,
  parameter int level     = 0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [2*(ctrl_bit+log_n_add+bit_width)-1:0] in,
  input  logic [1:0]                                  stall_in,
  output logic [2*(ctrl_bit+log_n_add+bit_width)-1:0] out,
  output logic [1:0]                                  stall
);
  localparam int W        = ctrl_bit + log_n_add + bit_width;
  localparam int DEST_BIT = W - 1 - log_n_add + level;

  logic [W-1:0] in_p0   [2];
  logic [1:0]   req_p0  [2];
  logic [1:0]   vld_p0;
  logic [1:0]   dest_p0;
  logic [1:0]   free_p0;
  logic [1:0]   gnt_any_p0;
  logic [1:0]   gnt_src_p0;
  logic [1:0]   contend_p0;
  logic [1:0]   granted_p0;
  logic [W-1:0] out_p1  [2];
  logic [1:0]   vld_p1;
  logic [1:0]   rr_ptr;

  // Stage p0: unpack lanes, route and arbitrate
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      in_p0[i]   = in[i*W +: W];
      vld_p0[i]  = in_p0[i][W-1];
      dest_p0[i] = in_p0[i][DEST_BIT];
      vld_p1[i]  = out_p1[i][W-1];
    end
  end

  always_comb begin
    req_p0[0]  = '0;
    req_p0[1]  = '0;
    free_p0    = '0;
    gnt_any_p0 = '0;
    gnt_src_p0 = '0;
    contend_p0 = '0;
    granted_p0 = '0;
    for (int j = 0; j < 2; j++) begin
      req_p0[j]  = vld_p0 & {dest_p0[1] == 1'(j), dest_p0[0] == 1'(j)};
      free_p0[j] = ~vld_p1[j] | ~stall_in[j];
      // A held output keeps its word, so nobody may be granted into it.
      if (!rst && free_p0[j] && (req_p0[j] != 2'b00)) begin
        gnt_any_p0[j] = 1'b1;
        contend_p0[j] = &req_p0[j];
        gnt_src_p0[j] = contend_p0[j] ? rr_ptr[j] : req_p0[j][1];
        granted_p0[gnt_src_p0[j]] = 1'b1;
      end
    end
    stall = vld_p0 & ~granted_p0;
  end

  // Stage p1: registered output lanes and round-robin pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_p1[0] <= '0;
      out_p1[1] <= '0;
      rr_ptr    <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (free_p0[j]) begin
          out_p1[j] <= gnt_any_p0[j] ? in_p0[gnt_src_p0[j]] : '0;
        end
        if (contend_p0[j]) begin
          rr_ptr[j] <= ~gnt_src_p0[j];
        end
      end
    end
  end

  assign out = {out_p1[1], out_p1[0]};

endmodule

// File: tb/tb_noc_switch_node.sv
// Bench for noc_switch_node (W=8, level=0): directed vectors with literal
// expectations plus a queue-based reference model checked every cycle.
module tb_noc_switch_node;
  logic        clk;
  logic        rst;
  logic [15:0] in_r;
  logic [1:0]  stall_in_r;
  logic [15:0] out_w;
  logic [1:0]  stall_w;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  logic [7:0] m_out [2];
  logic [1:0] m_rr;

  noc_switch_node #(
    .bit_width(4),
    .log_n_add(3),
    .ctrl_bit (1),
    .level    (0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in_r),
    .stall_in(stall_in_r),
    .out     (out_w),
    .stall   (stall_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per output, list the requesting lanes, then pick a winner.
  always @(negedge clk) begin
    logic [7:0] w [2];
    logic [7:0] nxt [2];
    logic [1:0] granted;
    logic [1:0] exp_stall;
    int q[$];
    int win;
    bit free;
    w[0] = in_r[7:0];
    w[1] = in_r[15:8];
    granted = 2'b00;
    for (int j = 0; j < 2; j++) begin
      q.delete();
      for (int i = 0; i < 2; i++)
        if (w[i][7] && (w[i][4] == j[0])) q.push_back(i);
      free = (m_out[j][7] == 1'b0) || (stall_in_r[j] == 1'b0);
      nxt[j] = m_out[j];
      if (free) nxt[j] = 8'h00;
      if (!rst && free && q.size() > 0) begin
        win = (q.size() == 2) ? int'(m_rr[j]) : q[0];
        granted[win] = 1'b1;
        if (q.size() == 2) m_rr[j] = (win == 0);
        nxt[j] = w[win];
      end
    end
    exp_stall = {w[1][7] & ~granted[1], w[0][7] & ~granted[0]};
    if (chk_en) begin
      chk("model_out", out_w, {m_out[1], m_out[0]});
      chk("model_stall", {14'd0, stall_w}, {14'd0, exp_stall});
    end
    if (rst) begin
      nxt[0] = 8'h00;
      nxt[1] = 8'h00;
      m_rr   = 2'b00;
    end
    m_out[0] = nxt[0];
    m_out[1] = nxt[1];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    in_r = 16'h0000;
    step();
    rst  = 1'b0;
  endtask

  task automatic settle_stall(input string nm, input logic [1:0] exp);
    #1;
    chk(nm, {14'd0, stall_w}, {14'd0, exp});
  endtask

  initial begin
    m_out[0] = 8'h00;
    m_out[1] = 8'h00;
    m_rr     = 2'b00;
    rst        = 1'b1;
    in_r       = 16'h9A9A;
    stall_in_r = 2'b00;

    // Reset holds outputs empty and reflects V on stall
    step();
    chk_en = 1;
    chk("rst_out_a", out_w, 16'h0000);
    settle_stall("rst_stall_a", 2'b11);
    step();
    chk("rst_out_b", out_w, 16'h0000);
    settle_stall("rst_stall_b", 2'b11);
    rst = 1'b0;
    settle_stall("post_rst_stall", 2'b10);
    step();
    chk("post_rst_out", out_w, 16'h9A00);

    // Parallel routing
    in_r = 16'h0000;
    step();
    in_r = 16'h938A;
    settle_stall("par_stall", 2'b00);
    step();
    chk("par_out", out_w, 16'h938A);

    // Contention on out1, lane0 favoured after reset
    do_reset();
    in_r = 16'h9C95;
    settle_stall("cont_stall0", 2'b10);
    step();
    chk("cont_out1_a", {8'h00, out_w[15:8]}, 16'h0095);
    in_r = 16'h9C00;
    settle_stall("cont_stall1", 2'b00);
    step();
    chk("cont_out1_b", {8'h00, out_w[15:8]}, 16'h009C);
    in_r = 16'h9C95;
    settle_stall("cont_rr_flip", 2'b01);
    step();
    chk("cont_out1_c", {8'h00, out_w[15:8]}, 16'h009C);

    // Alternation under continuous contention
    do_reset();
    for (int k = 0; k < 6; k++) begin
      in_r = {8'h98 | 8'(k), 8'h90 | 8'(k)};
      step();
      chk($sformatf("alt_%0d", k), {8'h00, out_w[15:8]},
          {8'h00, (k % 2) ? (8'h98 | 8'(k)) : (8'h90 | 8'(k))});
    end

    // Downstream stall holds out0
    in_r = 16'h008A;
    step();
    chk("ds_load", {8'h00, out_w[7:0]}, 16'h008A);
    stall_in_r = 2'b01;
    in_r = 16'h0085;
    for (int k = 0; k < 3; k++) begin
      settle_stall($sformatf("ds_stall_%0d", k), 2'b01);
      step();
      chk($sformatf("ds_hold_%0d", k), {8'h00, out_w[7:0]}, 16'h008A);
    end
    stall_in_r = 2'b00;
    settle_stall("ds_release_stall", 2'b00);
    step();
    chk("ds_release_out", {8'h00, out_w[7:0]}, 16'h0085);

    // Invalid words are neither stalled nor forwarded
    in_r = 16'h7F7F;
    settle_stall("inv_stall", 2'b00);
    step();
    chk("inv_out", out_w, 16'h0000);

    // Reset mid-operation discards buffered words
    in_r = 16'h938A;
    step();
    chk("mid_load", out_w, 16'h938A);
    rst = 1'b1;
    settle_stall("mid_rst_stall", 2'b11);
    step();
    chk("mid_rst_out", out_w, 16'h0000);
    rst = 1'b0;
    settle_stall("mid_post_stall", 2'b00);
    step();
    chk("mid_post_out", out_w, 16'h938A);

    in_r = 16'h0000;
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, limit %0d", 100000);
    $fatal(1, "timeout");
  end

endmodule
